dff_bank_arbiter: RTL

- Round-robin arbiter and sequencer sharing one bank of D-flip-flop storage registers between NREQ requesters.
- Each requester issues a single-word read or write and holds its request until it receives a done pulse.
- The block owns the register bank: it latches the winning command, performs the access, then releases the grant.
- Sits between the requesting blocks and the shared storage; this is the first clocked, reset-bearing consumer of the flop cells.

---
 rtl/dff_bank_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/dff_bank_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dff_bank_pkg.sv
// ============================================================================
// Module   : dff_bank_pkg
// Purpose  : Shared types, default widths and one-hot helper for the DFF bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dff_bank_pkg;

    localparam int c_NREQ_DEFAULT  = 4;
    localparam int c_W_DEFAULT     = 8;
    localparam int c_DEPTH_DEFAULT = 16;
    localparam int c_AW_DEFAULT    = 4;

    // One-hot helper is sized for the largest supported requester count.
    localparam int c_MAX_NREQ  = 8;
    localparam int c_MAX_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    function automatic logic [c_MAX_NREQ-1:0] onehot(input logic [c_MAX_IDX_W-1:0] idx);
        logic [c_MAX_NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick: first set req bit from ptr upward.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   winner,
    output logic            valid
);

    // Scan farthest-to-nearest so the requester closest to ptr is written last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                winner = IW'((int'(ptr) + k) % NREQ);
                valid  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dff_bank_arbiter.sv
// ============================================================================
// Module   : dff_bank_arbiter
// Purpose  : Round-robin sequencer sharing one DFF register bank between
//            NREQ requesters. Optional DFF_BANK_LOCK_EN adds a per-requester
//            lock input that lets a winner keep priority back-to-back.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dff_bank_arbiter
    import dff_bank_pkg::*;
#(
    parameter int NREQ  = c_NREQ_DEFAULT,
    parameter int W     = c_W_DEFAULT,
    parameter int DEPTH = c_DEPTH_DEFAULT,
    parameter int AW    = c_AW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*W-1:0]  wdata,
`ifdef DFF_BANK_LOCK_EN
    input  logic [NREQ-1:0]    lock,
`endif
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [W-1:0]       rdata,
    output logic               busy
);

    localparam int c_IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            r_state;
    logic [c_IW-1:0]   r_ptr;
    logic [c_IW-1:0]   r_winner;
    logic              r_we;
    logic [AW-1:0]     r_addr;
    logic [W-1:0]      r_wdata;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_done;
    logic [W-1:0]      r_rdata;
    logic [W-1:0]      r_bank [DEPTH];

    logic [c_IW-1:0]   w_winner;
    logic              w_valid;
    logic [NREQ-1:0]   w_win_oh;
    logic              w_in_range;
    logic [c_IW-1:0]   w_next_ptr;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (c_IW)
    ) u_rr_arbiter (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .valid  (w_valid)
    );

    assign w_win_oh   = NREQ'(onehot(c_MAX_IDX_W'(w_winner)));
    assign w_in_range = (int'(r_addr) < DEPTH);

    always_comb begin
        w_next_ptr = (int'(r_winner) == NREQ - 1) ? '0 : r_winner + c_IW'(1);
`ifdef DFF_BANK_LOCK_EN
        // A locked winner still requesting keeps top priority for the next round.
        if (lock[r_winner] && req[r_winner]) begin
            w_next_ptr = r_winner;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_winner <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_rdata  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_bank[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_gnt    <= w_win_oh;
                        r_winner <= w_winner;
                        r_we     <= we[w_winner];
                        r_addr   <= addr[w_winner*AW +: AW];
                        r_wdata  <= wdata[w_winner*W +: W];
                        r_state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Out-of-range addresses drop writes and read back zero.
                    if (r_we) begin
                        if (w_in_range) begin
                            r_bank[r_addr] <= r_wdata;
                        end
                    end else begin
                        r_rdata <= w_in_range ? r_bank[r_addr] : '0;
                    end
                    r_done  <= r_gnt;
                    r_state <= RELEASE;
                end
                RELEASE: begin
                    r_gnt   <= '0;
                    r_done  <= '0;
                    r_ptr   <= w_next_ptr;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign done  = r_done;
    assign rdata = r_rdata;
    assign busy  = (r_state != IDLE);

endmodule

`default_nettype wire
